// File: rtl/booth4_pkg.sv
// rtl/booth4_pkg.sv - shared types and default sizing for the Booth radix-4 share arbiter
package booth4_pkg;

    localparam int DEF_W       = 8;
    localparam int DEF_N_REQ   = 4;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant picker, pointer kept by the caller
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic          found;
    logic [IW-1:0] idx;

    // scan last+1, last+2, ... modulo N and take the first pending request
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last) + k) % N);
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/booth4_share_arb.sv
// rtl/booth4_share_arb.sv - round-robin sharing of one Booth radix-4 multiplier among N requesters
module booth4_share_arb
    import booth4_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int W       = DEF_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_m,
    input  logic [N_REQ*W-1:0] req_q,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output logic [2*W-1:0]     rsp_p,
    output logic               rsp_err,
    output logic               mul_start,
    output logic [W-1:0]       mul_m,
    output logic [W-1:0]       mul_q,
    input  logic [W-1:0]       mul_dout,
    input  logic               mul_oa,
    input  logic               mul_oq,
    input  logic               mul_stop,
    output logic               mul_flush
);

    localparam int IW  = $clog2(N_REQ);
    localparam int WDW = $clog2(TIMEOUT + 1);

    arb_state_t       state, state_nxt;
    logic [IW-1:0]    last;
    logic [IW-1:0]    gidx;
    logic [IW-1:0]    gnt_idx;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] gidx_oh;
    logic             seen_a, seen_q;
    logic [WDW-1:0]   wd;
    logic             any_req, wd_expired, rsp_done, good_stop;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req     (req_valid),
        .last    (last),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign any_req    = |gnt;
    assign gidx_oh    = N_REQ'(1) << gidx;
    // mul_stop in the same cycle beats the watchdog
    assign wd_expired = (state == WAIT) && (wd == WDW'(TIMEOUT)) && !mul_stop;
    assign rsp_done   = (state == RESP) && |(rsp_ready & gidx_oh);
    // a half arriving together with mul_stop still counts as seen
    assign good_stop  = (seen_a | mul_oa) & (seen_q | mul_oq);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and per-state strobes
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        mul_start = 1'b0;
        mul_flush = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) state_nxt = ISSUE;
            end
            ISSUE: begin
                req_ready = gidx_oh;
                mul_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (mul_stop) begin
                    state_nxt = RESP;
                end else if (wd_expired) begin
                    mul_flush = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = gidx_oh;
                if (rsp_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // grant pointer, operand latch, product assembly and watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last    <= IW'(N_REQ - 1);
            gidx    <= '0;
            mul_m   <= '0;
            mul_q   <= '0;
            rsp_p   <= '0;
            rsp_err <= 1'b0;
            seen_a  <= 1'b0;
            seen_q  <= 1'b0;
            wd      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        last  <= gnt_idx;
                        gidx  <= gnt_idx;
                        mul_m <= req_m[gnt_idx*W +: W];
                        mul_q <= req_q[gnt_idx*W +: W];
                    end
                end
                ISSUE: begin
                    wd      <= '0;
                    seen_a  <= 1'b0;
                    seen_q  <= 1'b0;
                    rsp_p   <= '0;
                    rsp_err <= 1'b0;
                end
                WAIT: begin
                    if (wd != WDW'(TIMEOUT)) wd <= wd + 1'b1;
                    if (mul_oa) begin
                        rsp_p[2*W-1:W] <= mul_dout;
                        seen_a         <= 1'b1;
                    end
                    if (mul_oq) begin
                        rsp_p[W-1:0] <= mul_dout;
                        seen_q       <= 1'b1;
                    end
                    if ((mul_stop && !good_stop) || wd_expired) begin
                        rsp_p   <= '0;
                        rsp_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
